// File: rtl/projection_histogram.sv
// Row/column projection histogram: counts set pixels per column (x) and per row (y),
// then streams both bin arrays over two valid/ready channels and reports the peak bins.
module projection_histogram #(
  parameter int IMWIDTH    = 240,
  parameter int IMHEIGHT   = 180,
  parameter int COUNT_W    = 8,
  parameter int XAW        = 8,
  parameter int YAW        = 8,
  parameter int AUTO_CLEAR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixelValid,
  input  logic               pixelData,
  input  logic [XAW-1:0]     xAddress,
  input  logic [YAW-1:0]     yAddress,
  input  logic               startHistogram,
  input  logic               stopHistogram,
  input  logic               clearHistogram,
  input  logic               readHistogram,
  input  logic               outReady,
  output logic [COUNT_W-1:0] xHistogramOut,
  output logic [COUNT_W-1:0] yHistogramOut,
  output logic               xValid,
  output logic               yValid,
  output logic [XAW-1:0]     xPeakIndex,
  output logic [YAW-1:0]     yPeakIndex,
  output logic               histogramClear,
  output logic               readDone,
  output logic               overflow,
  output logic               ready
);

  localparam int CLR_N = (IMWIDTH > IMHEIGHT) ? IMWIDTH : IMHEIGHT;
  localparam int CLR_W = $clog2(CLR_N + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, COMPUTE, READ} state_t;

  state_t state, state_nxt;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

  // Reset asserts asynchronously but releases only after two clean edges.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  logic [COUNT_W-1:0] x_bin [IMWIDTH];
  logic [COUNT_W-1:0] y_bin [IMHEIGHT];

  logic [CLR_W-1:0]   clr_cnt;
  logic               run_after_clr;
  logic               clr_last, x_clr, y_clr;
  logic               pix, x_inc, y_inc, ovf_set;
  logic [COUNT_W-1:0] x_cur, y_cur;

  assign clr_last = (state == CLEAR) && (32'(clr_cnt) == CLR_N - 1);
  assign x_clr    = (state == CLEAR) && (32'(clr_cnt) < IMWIDTH);
  assign y_clr    = (state == CLEAR) && (32'(clr_cnt) < IMHEIGHT);

  assign pix     = (state == COMPUTE) && pixelValid && pixelData;
  assign x_inc   = pix && (32'(xAddress) < IMWIDTH);
  assign y_inc   = pix && (32'(yAddress) < IMHEIGHT);
  assign x_cur   = x_bin[xAddress];
  assign y_cur   = y_bin[yAddress];
  assign ovf_set = (x_inc && (x_cur == {COUNT_W{1'b1}})) ||
                   (y_inc && (y_cur == {COUNT_W{1'b1}}));

  // Read path: p0 = fetch address, p1 = registered bin read, p2 = output beat.
  logic [XAW:0]       x_addr_p0;
  logic [YAW:0]       y_addr_p0;
  logic               x_vld_p1, y_vld_p1;
  logic [COUNT_W-1:0] x_mem_p1, y_mem_p1;
  logic [XAW-1:0]     x_idx_p1, x_idx_p2;
  logic [YAW-1:0]     y_idx_p1, y_idx_p2;
  logic               x_fin, y_fin;
  logic [COUNT_W-1:0] x_max, y_max;
  logic [XAW-1:0]     x_pk, x_pk_nxt;
  logic [YAW-1:0]     y_pk, y_pk_nxt;
  logic               x_adv, y_adv, x_load, y_load, x_more, y_more;
  logic               x_xfer, y_xfer, x_last, y_last, x_better, y_better;
  logic               done_nxt;

  assign x_adv    = !xValid || outReady;
  assign y_adv    = !yValid || outReady;
  assign x_load   = (state == READ) && (!x_vld_p1 || x_adv);
  assign y_load   = (state == READ) && (!y_vld_p1 || y_adv);
  assign x_more   = 32'(x_addr_p0) < IMWIDTH;
  assign y_more   = 32'(y_addr_p0) < IMHEIGHT;
  assign x_xfer   = (state == READ) && xValid && outReady;
  assign y_xfer   = (state == READ) && yValid && outReady;
  assign x_last   = x_xfer && (32'(x_idx_p2) == IMWIDTH - 1);
  assign y_last   = y_xfer && (32'(y_idx_p2) == IMHEIGHT - 1);
  assign x_better = x_xfer && (xHistogramOut > x_max);
  assign y_better = y_xfer && (yHistogramOut > y_max);
  assign x_pk_nxt = x_better ? x_idx_p2 : x_pk;
  assign y_pk_nxt = y_better ? y_idx_p2 : y_pk;
  assign done_nxt = (state == READ) && (x_fin || x_last) && (y_fin || y_last);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (startHistogram)      state_nxt = (AUTO_CLEAR != 0) ? CLEAR : COMPUTE;
        else if (clearHistogram) state_nxt = CLEAR;
        else if (readHistogram)  state_nxt = READ;
      end
      CLEAR:   if (clr_last) state_nxt = run_after_clr ? COMPUTE : IDLE;
      COMPUTE: if (stopHistogram) state_nxt = IDLE;
      READ:    if (done_nxt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready          = (state == IDLE);
  assign histogramClear = clr_last;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      clr_cnt       <= '0;
      run_after_clr <= 1'b0;
      overflow      <= 1'b0;
      readDone      <= 1'b0;
      xPeakIndex    <= '0;
      yPeakIndex    <= '0;
      x_addr_p0     <= '0;
      y_addr_p0     <= '0;
      x_vld_p1      <= 1'b0;
      y_vld_p1      <= 1'b0;
      xValid        <= 1'b0;
      yValid        <= 1'b0;
      xHistogramOut <= '0;
      yHistogramOut <= '0;
      x_fin         <= 1'b0;
      y_fin         <= 1'b0;
      x_max         <= '0;
      y_max         <= '0;
      x_pk          <= '0;
      y_pk          <= '0;
    end else begin
      readDone <= done_nxt;
      if (done_nxt) begin
        xPeakIndex <= x_pk_nxt;
        yPeakIndex <= y_pk_nxt;
      end

      if (state == IDLE) begin
        clr_cnt       <= '0;
        run_after_clr <= startHistogram && (AUTO_CLEAR != 0);
      end else if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end

      if (state == CLEAR) overflow <= 1'b0;
      else if (ovf_set)   overflow <= 1'b1;

      if (state != READ) begin
        x_addr_p0 <= '0;
        y_addr_p0 <= '0;
        x_vld_p1  <= 1'b0;
        y_vld_p1  <= 1'b0;
        xValid    <= 1'b0;
        yValid    <= 1'b0;
        x_fin     <= 1'b0;
        y_fin     <= 1'b0;
        x_max     <= '0;
        y_max     <= '0;
        x_pk      <= '0;
        y_pk      <= '0;
      end else begin
        if (x_load) begin
          x_vld_p1 <= x_more;
          if (x_more) x_addr_p0 <= x_addr_p0 + 1'b1;
        end
        if (y_load) begin
          y_vld_p1 <= y_more;
          if (y_more) y_addr_p0 <= y_addr_p0 + 1'b1;
        end
        if (x_adv) begin
          xValid <= x_vld_p1;
          if (x_vld_p1) xHistogramOut <= x_mem_p1;
        end
        if (y_adv) begin
          yValid <= y_vld_p1;
          if (y_vld_p1) yHistogramOut <= y_mem_p1;
        end
        if (x_last) x_fin <= 1'b1;
        if (y_last) y_fin <= 1'b1;
        if (x_better) begin
          x_max <= xHistogramOut;
          x_pk  <= x_idx_p2;
        end
        if (y_better) begin
          y_max <= yHistogramOut;
          y_pk  <= y_idx_p2;
        end
      end
    end
  end

  // Bin storage and its registered read port are not reset; only a CLEAR zeroes bins.
  always_ff @(posedge clk) begin
    if (x_clr)      x_bin[XAW'(clr_cnt)] <= '0;
    else if (x_inc) x_bin[xAddress]      <= sat_inc(x_cur);
    if (y_clr)      y_bin[YAW'(clr_cnt)] <= '0;
    else if (y_inc) y_bin[yAddress]      <= sat_inc(y_cur);

    if (x_load && x_more) begin
      x_mem_p1 <= x_bin[XAW'(x_addr_p0)];
      x_idx_p1 <= XAW'(x_addr_p0);
    end
    if (y_load && y_more) begin
      y_mem_p1 <= y_bin[YAW'(y_addr_p0)];
      y_idx_p1 <= YAW'(y_addr_p0);
    end
    if ((state == READ) && x_adv && x_vld_p1) x_idx_p2 <= x_idx_p1;
    if ((state == READ) && y_adv && y_vld_p1) y_idx_p2 <= y_idx_p1;
  end

endmodule

// File: tb/tb_projection_histogram.sv
// Directed bench for projection_histogram: default-size instance plus a small AUTO_CLEAR=1 instance.
module tb_projection_histogram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       pixelValid, pixelData;
  logic [7:0] xAddress, yAddress;
  logic       startHistogram, stopHistogram, clearHistogram, readHistogram, outReady;
  logic [7:0] xHistogramOut, yHistogramOut;
  logic       xValid, yValid;
  logic [7:0] xPeakIndex, yPeakIndex;
  logic       histogramClear, readDone, overflow, ready;

  logic       a_pixelValid, a_pixelData;
  logic [2:0] a_xAddress, a_yAddress;
  logic       a_start, a_stop, a_clear, a_read, a_outReady;
  logic [3:0] a_xOut, a_yOut;
  logic       a_xValid, a_yValid;
  logic [2:0] a_xPeak, a_yPeak;
  logic       a_histogramClear, a_readDone, a_overflow, a_ready;

  projection_histogram dut (
    .clk(clk), .reset(reset), .pixelValid(pixelValid), .pixelData(pixelData),
    .xAddress(xAddress), .yAddress(yAddress),
    .startHistogram(startHistogram), .stopHistogram(stopHistogram),
    .clearHistogram(clearHistogram), .readHistogram(readHistogram), .outReady(outReady),
    .xHistogramOut(xHistogramOut), .yHistogramOut(yHistogramOut),
    .xValid(xValid), .yValid(yValid), .xPeakIndex(xPeakIndex), .yPeakIndex(yPeakIndex),
    .histogramClear(histogramClear), .readDone(readDone), .overflow(overflow), .ready(ready)
  );

  projection_histogram #(
    .IMWIDTH(8), .IMHEIGHT(6), .COUNT_W(4), .XAW(3), .YAW(3), .AUTO_CLEAR(1)
  ) dut_auto (
    .clk(clk), .reset(reset), .pixelValid(a_pixelValid), .pixelData(a_pixelData),
    .xAddress(a_xAddress), .yAddress(a_yAddress),
    .startHistogram(a_start), .stopHistogram(a_stop),
    .clearHistogram(a_clear), .readHistogram(a_read), .outReady(a_outReady),
    .xHistogramOut(a_xOut), .yHistogramOut(a_yOut),
    .xValid(a_xValid), .yValid(a_yValid), .xPeakIndex(a_xPeak), .yPeakIndex(a_yPeak),
    .histogramClear(a_histogramClear), .readDone(a_readDone), .overflow(a_overflow),
    .ready(a_ready)
  );

  int tests = 0;
  int fails = 0;
  int xb[256];
  int yb[256];
  int xn, yn, rd_cnt, rd_cyc, last_cyc, stall_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(output int n);
    clearHistogram = 1'b1;
    n = -1;
    for (int i = 1; i <= 600; i++) begin
      tick();
      clearHistogram = 1'b0;
      if (histogramClear === 1'b1) begin
        n = i;
        break;
      end
    end
    tick();
  endtask

  task automatic do_start();
    startHistogram = 1'b1;
    tick();
    startHistogram = 1'b0;
  endtask

  task automatic pixels(input int x, input int y, input int n, input bit last_stop);
    for (int i = 0; i < n; i++) begin
      pixelValid    = 1'b1;
      pixelData     = 1'b1;
      xAddress      = 8'(x);
      yAddress      = 8'(y);
      stopHistogram = last_stop && (i == n - 1);
      tick();
    end
    pixelValid    = 1'b0;
    pixelData     = 1'b0;
    stopHistogram = 1'b0;
  endtask

  task automatic do_read(input bit rand_mode);
    logic pxv, pyv, prdy;
    logic [7:0] pxd, pyd;
    xn = 0; yn = 0; rd_cnt = 0; rd_cyc = -1; last_cyc = -1; stall_err = 0;
    pxv = 1'b0; pyv = 1'b0; prdy = 1'b0; pxd = '0; pyd = '0;
    readHistogram = 1'b1;
    outReady      = 1'b1;
    tick();
    readHistogram = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      outReady = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pxv && !prdy && (xValid !== 1'b1 || xHistogramOut !== pxd)) stall_err++;
      if (pyv && !prdy && (yValid !== 1'b1 || yHistogramOut !== pyd)) stall_err++;
      if (xValid === 1'b1 && outReady) begin
        if (xn < 256) xb[xn] = int'(xHistogramOut);
        xn++;
        last_cyc = c;
      end
      if (yValid === 1'b1 && outReady) begin
        if (yn < 256) yb[yn] = int'(yHistogramOut);
        yn++;
        last_cyc = c;
      end
      if (readDone === 1'b1) begin
        rd_cnt++;
        rd_cyc = c;
      end
      pxv = xValid; pyv = yValid; prdy = outReady; pxd = xHistogramOut; pyd = yHistogramOut;
      if (rd_cnt > 0 && c > rd_cyc + 3) break;
      tick();
    end
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    tests++;
    if ({xValid, yValid, readDone, overflow, histogramClear} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000", {xValid, yValid, readDone, overflow, histogramClear});
    end
    tests++;
    if (xHistogramOut !== 8'd0 || yHistogramOut !== 8'd0 || xPeakIndex !== 8'd0 || yPeakIndex !== 8'd0) begin
      fails++;
      $display("FAIL reset_data: got x=%0d y=%0d xp=%0d yp=%0d expected all 0",
               xHistogramOut, yHistogramOut, xPeakIndex, yPeakIndex);
    end
    reset = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_basic();
    int n, errs;
    do_clear(n);
    do_start();
    pixels(3, 7, 5, 1'b1);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL stop_to_idle: ready got %b expected 1", ready);
    end
    do_read(1'b0);
    tests++;
    if (xn !== 240 || yn !== 180) begin
      fails++;
      $display("FAIL basic_beats: got x=%0d y=%0d expected x=240 y=180", xn, yn);
    end
    errs = 0;
    for (int i = 0; i < 240; i++) if (xb[i] != ((i == 3) ? 5 : 0)) errs++;
    for (int i = 0; i < 180; i++) if (yb[i] != ((i == 7) ? 5 : 0)) errs++;
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL basic_bins: got %0d wrong bins (x3=%0d y7=%0d) expected 0 wrong, x3=5 y7=5", errs, xb[3], yb[7]);
    end
    tests++;
    if (rd_cnt != 1 || rd_cyc != last_cyc + 1) begin
      fails++;
      $display("FAIL basic_readdone: got pulses=%0d at %0d expected 1 at %0d", rd_cnt, rd_cyc, last_cyc + 1);
    end
    tests++;
    if (xPeakIndex !== 8'd3 || yPeakIndex !== 8'd7) begin
      fails++;
      $display("FAIL basic_peak: got x=%0d y=%0d expected x=3 y=7", xPeakIndex, yPeakIndex);
    end
  endtask

  task automatic test_overflow();
    int n;
    do_clear(n);
    tests++;
    if (n != 240) begin
      fails++;
      $display("FAIL clear_len: got %0d expected 240", n);
    end
    do_start();
    pixels(0, 0, 300, 1'b1);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: got %b expected 1", overflow);
    end
    do_read(1'b0);
    tests++;
    if (xb[0] != 255 || yb[0] != 255 || xn != 240) begin
      fails++;
      $display("FAIL saturate: got x0=%0d y0=%0d beats=%0d expected 255 255 240", xb[0], yb[0], xn);
    end
    do_clear(n);
    tests++;
    if (n != 240 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_clear: got len=%0d ovf=%b expected 240 0", n, overflow);
    end
  endtask

  task automatic test_random_stall();
    int n, errs;
    int ex[240];
    int ey[180];
    for (int i = 0; i < 240; i++) ex[i] = 0;
    for (int i = 0; i < 180; i++) ey[i] = 0;
    ex[10] = 3; ey[20] = 3; ex[100] = 2; ey[5] = 2;
    ex[239] = 4; ey[179] = 4; ex[50] = 4; ey[60] = 4;
    do_clear(n);
    do_start();
    pixelValid = 1'b1; pixelData = 1'b0; xAddress = 8'd10; yAddress = 8'd20;
    tick();
    pixelValid = 1'b0; pixelData = 1'b1;
    tick();
    pixels(10, 20, 3, 1'b0);
    pixels(100, 5, 2, 1'b0);
    pixels(239, 179, 4, 1'b0);
    pixels(50, 60, 4, 1'b1);
    do_read(1'b1);
    tests++;
    if (xn != 240 || yn != 180) begin
      fails++;
      $display("FAIL stall_beats: got x=%0d y=%0d expected x=240 y=180", xn, yn);
    end
    errs = 0;
    for (int i = 0; i < 240; i++) if (xb[i] != ex[i]) errs++;
    for (int i = 0; i < 180; i++) if (yb[i] != ey[i]) errs++;
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL stall_bins: got %0d wrong bins expected 0", errs);
    end
    tests++;
    if (stall_err != 0) begin
      fails++;
      $display("FAIL stall_hold: got %0d unstable stalled beats expected 0", stall_err);
    end
    tests++;
    if (rd_cnt != 1 || rd_cyc != last_cyc + 1) begin
      fails++;
      $display("FAIL stall_readdone: got pulses=%0d at %0d expected 1 at %0d", rd_cnt, rd_cyc, last_cyc + 1);
    end
    tests++;
    if (xPeakIndex !== 8'd50 || yPeakIndex !== 8'd60) begin
      fails++;
      $display("FAIL peak_tie: got x=%0d y=%0d expected x=50 y=60", xPeakIndex, yPeakIndex);
    end
  endtask

  task automatic test_out_of_range();
    int n, errs;
    do_clear(n);
    do_start();
    pixels(245, 10, 1, 1'b1);
    do_read(1'b0);
    errs = 0;
    for (int i = 0; i < 240; i++) if (xb[i] != 0) errs++;
    for (int i = 0; i < 180; i++) if (yb[i] != ((i == 10) ? 1 : 0)) errs++;
    tests++;
    if (errs != 0 || xn != 240) begin
      fails++;
      $display("FAIL out_of_range: got %0d wrong bins y10=%0d beats=%0d expected 0 wrong y10=1 240", errs, yb[10], xn);
    end
    tests++;
    if (xPeakIndex !== 8'd0 || yPeakIndex !== 8'd10) begin
      fails++;
      $display("FAIL oor_peak: got x=%0d y=%0d expected x=0 y=10", xPeakIndex, yPeakIndex);
    end
  endtask

  task automatic test_start_clear();
    int n;
    do_clear(n);
    startHistogram = 1'b1;
    clearHistogram = 1'b1;
    tick();
    startHistogram = 1'b0;
    clearHistogram = 1'b0;
    pixels(1, 1, 1, 1'b1);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL start_priority: ready got %b expected 1", ready);
    end
    do_read(1'b0);
    tests++;
    if (xb[1] != 1 || yb[1] != 1 || xb[0] != 0) begin
      fails++;
      $display("FAIL start_priority_bins: got x1=%0d y1=%0d x0=%0d expected 1 1 0", xb[1], yb[1], xb[0]);
    end
  endtask

  task automatic test_auto_clear();
    int n, bad_ready, errs, an, adone;
    int ab[8];
    n = -1; bad_ready = 0;
    a_start = 1'b1;
    a_clear = 1'b1;
    tick();
    a_start = 1'b0;
    a_clear = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (a_ready !== 1'b0) bad_ready++;
      if (a_histogramClear === 1'b1) begin
        n = i;
        break;
      end
      tick();
    end
    tick();
    if (a_ready !== 1'b0) bad_ready++;
    tests++;
    if (n != 8 || bad_ready != 0) begin
      fails++;
      $display("FAIL auto_clear: got len=%0d idle_cycles=%0d expected 8 0", n, bad_ready);
    end
    a_pixelValid = 1'b1; a_pixelData = 1'b1; a_xAddress = 3'd2; a_yAddress = 3'd3; a_stop = 1'b1;
    tick();
    a_pixelValid = 1'b0; a_pixelData = 1'b0; a_stop = 1'b0;
    a_read = 1'b1; a_outReady = 1'b1;
    tick();
    a_read = 1'b0;
    an = 0; adone = 0;
    for (int c = 0; c < 100 && adone == 0; c++) begin
      if (a_xValid === 1'b1) begin
        if (an < 8) ab[an] = int'(a_xOut);
        an++;
      end
      if (a_readDone === 1'b1) adone = 1;
      else tick();
    end
    errs = 0;
    for (int i = 0; i < 8; i++) if (ab[i] != ((i == 2) ? 1 : 0)) errs++;
    tests++;
    if (an != 8 || errs != 0 || adone != 1) begin
      fails++;
      $display("FAIL auto_compute: got beats=%0d wrong=%0d done=%0d expected 8 0 1", an, errs, adone);
    end
    tests++;
    if (a_xPeak !== 3'd2 || a_yPeak !== 3'd3) begin
      fails++;
      $display("FAIL auto_peak: got x=%0d y=%0d expected x=2 y=3", a_xPeak, a_yPeak);
    end
  endtask

  task automatic test_reset_mid_read();
    readHistogram = 1'b1;
    outReady      = 1'b1;
    tick();
    readHistogram = 1'b0;
    repeat (20) tick();
    tests++;
    if (xValid !== 1'b1 || yValid !== 1'b1) begin
      fails++;
      $display("FAIL midread_active: got xv=%b yv=%b expected 1 1", xValid, yValid);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (xValid !== 1'b0 || yValid !== 1'b0 || xHistogramOut !== 8'd0 || xPeakIndex !== 8'd0) begin
      fails++;
      $display("FAIL midread_reset: got xv=%b yv=%b xd=%0d xp=%0d expected 0 0 0 0",
               xValid, yValid, xHistogramOut, xPeakIndex);
    end
    outReady = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL midread_ready: got %b expected 1", ready);
    end
    do_read(1'b0);
    tests++;
    if (xn != 240 || yn != 180 || xb[0] != 0 || xb[1] != 1 || xPeakIndex !== 8'd1) begin
      fails++;
      $display("FAIL midread_restart: got beats=%0d/%0d x0=%0d x1=%0d xp=%0d expected 240/180 0 1 1",
               xn, yn, xb[0], xb[1], xPeakIndex);
    end
  endtask

  initial begin
    reset = 1'b0;
    pixelValid = 1'b0; pixelData = 1'b0; xAddress = '0; yAddress = '0;
    startHistogram = 1'b0; stopHistogram = 1'b0; clearHistogram = 1'b0;
    readHistogram = 1'b0; outReady = 1'b0;
    a_pixelValid = 1'b0; a_pixelData = 1'b0; a_xAddress = '0; a_yAddress = '0;
    a_start = 1'b0; a_stop = 1'b0; a_clear = 1'b0; a_read = 1'b0; a_outReady = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_random_stall();
    test_out_of_range();
    test_start_clear();
    test_auto_clear();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/projection_histogram.md
PROJECTION_HISTOGRAM -- requirements
Module: projection_histogram

Interface
REQ-001 SHALL provide parameter IMWIDTH, default 240, number of x bins.
REQ-002 SHALL provide parameter IMHEIGHT, default 180, number of y bins.
REQ-003 SHALL provide parameter COUNT_W, default 8, bin counter width.
REQ-004 SHALL provide parameter XAW, default 8, x address width, with 2^XAW >= IMWIDTH.
REQ-005 SHALL provide parameter YAW, default 8, y address width, with 2^YAW >= IMHEIGHT.
REQ-006 SHALL provide parameter AUTO_CLEAR, default 0; when 1, every start first clears all bins.
REQ-007 SHALL have one clock; reset is asynchronous and active-low.
REQ-008 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- pixelValid  in  1  pixel qualifier.
- pixelData  in  1  binary pixel value.
- xAddress  in  XAW  pixel column.
- yAddress  in  YAW  pixel row.
- startHistogram, stopHistogram, clearHistogram, readHistogram  in  1 each  commands.
- outReady  in  1  sink accepts readout beats.
- xHistogramOut  out  COUNT_W  x bin value.
- yHistogramOut  out  COUNT_W  y bin value.
- xValid, yValid  out  1 each  readout beat valid.
- xPeakIndex  out  XAW  index of largest x bin at last read.
- yPeakIndex  out  YAW  index of largest y bin at last read.
- histogramClear  out  1  one-cycle pulse when a clear completes.
- readDone  out  1  one-cycle pulse when a read completes.
- overflow  out  1  sticky saturation flag.
- ready  out  1  high in IDLE only.

Function
REQ-009 SHALL implement states IDLE, CLEAR, COMPUTE, READ.
REQ-010 In IDLE, commands SHALL take priority start > clear > read; the transition occurs on the next edge.
REQ-011 Start SHALL go to COMPUTE, or to CLEAR and then directly to COMPUTE when AUTO_CLEAR=1.
REQ-012 CLEAR SHALL zero bin i of each axis in cycle i, last for max(IMWIDTH,IMHEIGHT) cycles, pulse histogramClear in its final cycle, clear overflow, and then go to IDLE (or COMPUTE per REQ-011).
REQ-013 In COMPUTE, a cycle with pixelValid=1 and pixelData=1 SHALL increment xBin[xAddress] and yBin[yAddress] by 1.
REQ-014 Increments SHALL saturate at 2^COUNT_W-1; an increment attempted at saturation SHALL set overflow.
REQ-015 An out-of-range address (xAddress>=IMWIDTH or yAddress>=IMHEIGHT) SHALL leave that axis unchanged, while the other axis still updates.
REQ-016 stopHistogram in COMPUTE SHALL return to IDLE next cycle; a pixel presented in the stop cycle SHALL still be counted.
REQ-017 Commands other than stop SHALL be ignored outside IDLE.
REQ-018 READ SHALL stream x bins 0..IMWIDTH-1 and y bins 0..IMHEIGHT-1 as two independent valid/ready channels sharing outReady.
REQ-019 The first beat SHALL be valid 2 cycles after READ entry, allowing for the registered memory read.
REQ-020 Output data and valid SHALL hold stable while valid=1 and outReady=0.
REQ-021 A beat SHALL transfer when valid=1 and outReady=1, and the channel SHALL then advance.
REQ-022 After its last beat a channel's valid SHALL drop and stay low.
REQ-023 readDone SHALL pulse once, in the cycle after both channels finish, and the state SHALL return to IDLE.
REQ-024 During READ, each axis SHALL track its maximum bin and index, with ties keeping the lowest index.
REQ-025 xPeakIndex and yPeakIndex SHALL update together with the readDone pulse and hold otherwise.
REQ-026 Bin contents SHALL persist across COMPUTE sessions until a clear.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE.
REQ-028 reset=0 SHALL immediately clear all outputs to 0: xValid, yValid, histogramClear, readDone, overflow, xHistogramOut, yHistogramOut, xPeakIndex and yPeakIndex.
REQ-029 ready SHALL be 1 from the first edge after reset release.
REQ-030 Reset SHALL NOT clear bin memory; reset mid-CLEAR or mid-READ SHALL abandon that operation, and a clear is required before the next valid accumulation.
REQ-031 Reset release SHALL be synchronised internally so the first active edge is glitch-free.

Verification
REQ-032 SHALL cover: clear, then start, then 5 pixels at (3,7), then stop, then read with outReady=1 -> x beat 3=5, y beat 7=5, all other beats 0, 240 x beats, 180 y beats, readDone a single pulse, xPeakIndex=3, yPeakIndex=7.
REQ-033 SHALL cover: 300 pixels at (0,0) with COUNT_W=8 -> bin value 255, overflow=1; a subsequent clear -> overflow=0 and histogramClear pulse after 240 cycles.
REQ-034 SHALL cover: read with outReady toggled pseudo-randomly -> no beat lost or duplicated, data stable while stalled, readDone after the final accepted beat.
REQ-035 SHALL cover: xAddress=245 with yAddress=10 -> y bin 10 increments, no x bin changes.
REQ-036 SHALL cover: start and clear asserted together in IDLE -> COMPUTE entered; with AUTO_CLEAR=1 -> CLEAR first, then COMPUTE without passing through IDLE.
REQ-037 SHALL cover: reset asserted mid-READ -> valids low immediately, ready=1 after release, a new read restarts at bin 0.
